// File: rtl/counter_monitor_pkg.sv
// Shared parameters and types for the up/down counter and its stream monitor.
package counter_pkg;
  localparam int CNT_W     = 10;
  localparam int CNT_MIN   = -263;
  localparam int CNT_MAX   = 269;
  localparam int RST_VAL   = 17;
  localparam int SKIP_VAL  = -47;
  localparam int UP_STEP   = 4;
  localparam int DN_STEP   = 10;
  localparam int ERR_LIMIT = 3;
  localparam int ERRCNT_W  = 8;
  localparam int CNT_N     = CNT_MAX - CNT_MIN + 1;
  // Two guard bits so step/wrap arithmetic never overflows before truncation
  localparam int CALC_W    = CNT_W + 2;

  typedef logic signed [CNT_W-1:0]  cnt_t;
  typedef logic signed [CALC_W-1:0] calc_t;

  typedef enum logic {SYNC, TRACK} state_e;
  typedef enum logic [1:0] {E_NONE, E_RANGE, E_SKIP, E_STEP} err_code_e;
endpackage

// File: rtl/counter_monitor_if.sv
// Counter sample stream plus monitor status; master is the counter side.
interface counter_monitor_if;
  import counter_pkg::*;

  logic                cnt_vld;
  cnt_t                cnt;
  logic                mode_out;
  logic                locked;
  logic                err;
  err_code_e           err_code;
  logic [ERRCNT_W-1:0] err_cnt;

  modport master (output cnt_vld, cnt,
                  input  mode_out, locked, err, err_code, err_cnt);
  modport slave  (input  cnt_vld, cnt,
                  output mode_out, locked, err, err_code, err_cnt);
endinterface

// File: rtl/counter_next.sv
// Legal successors of a counter value in both directions, plus value legality.
module counter_next
  import counter_pkg::*;
(
  input  cnt_t ref_val,
  input  cnt_t val,
  output cnt_t up_next,
  output cnt_t dn_next,
  output logic in_range,
  output logic legal
);
  calc_t r, v, up_raw, dn_raw, up_w, dn_w;

  always_comb begin
    r = calc_t'(ref_val);
    v = calc_t'(val);
    // The counter jumps over SKIP_VAL, so the value just before it takes a double step
    up_raw = (r == calc_t'(SKIP_VAL - UP_STEP)) ? r + calc_t'(2*UP_STEP) : r + calc_t'(UP_STEP);
    dn_raw = (r == calc_t'(SKIP_VAL + DN_STEP)) ? r - calc_t'(2*DN_STEP) : r - calc_t'(DN_STEP);
    up_w   = (up_raw > calc_t'(CNT_MAX)) ? up_raw - calc_t'(CNT_N) : up_raw;
    dn_w   = (dn_raw < calc_t'(CNT_MIN)) ? dn_raw + calc_t'(CNT_N) : dn_raw;
    up_next  = up_w[CNT_W-1:0];
    dn_next  = dn_w[CNT_W-1:0];
    in_range = (v >= calc_t'(CNT_MIN)) && (v <= calc_t'(CNT_MAX));
    legal    = in_range && (v != calc_t'(SKIP_VAL));
  end
endmodule

// File: rtl/counter_monitor.sv
// Passive monitor: decodes direction of the counter stream and flags illegal values/steps.
module counter_monitor
  import counter_pkg::*;
(
  input logic               clk,
  input logic               rst,
  counter_monitor_if.slave  bus
);
  localparam int CONSEC_W = $clog2(ERR_LIMIT + 1);

  state_e              state;
  cnt_t                ref_val;
  logic [CONSEC_W-1:0] consec;

  cnt_t      up_next, dn_next;
  logic      in_range, legal;
  logic      up_hit, dn_hit, hit;
  err_code_e bad_code;

  counter_next u_next (
    .ref_val  (ref_val),
    .val      (bus.cnt),
    .up_next  (up_next),
    .dn_next  (dn_next),
    .in_range (in_range),
    .legal    (legal)
  );

  always_comb begin
    up_hit   = (bus.cnt == up_next);
    dn_hit   = (bus.cnt == dn_next);
    bad_code = !in_range ? E_RANGE : (!legal ? E_SKIP : E_STEP);
    hit      = bus.cnt_vld && ((state == SYNC) ? !legal : !(up_hit || dn_hit));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SYNC;
      ref_val      <= cnt_t'(RST_VAL);
      consec       <= '0;
      bus.mode_out <= 1'b0;
      bus.locked   <= 1'b0;
      bus.err      <= 1'b0;
      bus.err_code <= E_NONE;
      bus.err_cnt  <= '0;
    end else begin
      bus.err <= hit;
      if (hit && (bus.err_cnt != '1))
        bus.err_cnt <= bus.err_cnt + 1'b1;
      if (bus.cnt_vld) begin
        bus.err_code <= hit ? bad_code : E_NONE;
        // Any legal value re-seeds the reference, so a bad step resynchronises
        if (legal)
          ref_val <= bus.cnt;
        unique case (state)
          SYNC: begin
            if (legal) begin
              state      <= TRACK;
              bus.locked <= 1'b1;
              consec     <= '0;
            end
          end
          TRACK: begin
            if (!hit) begin
              bus.mode_out <= up_hit;
              consec       <= '0;
            end else if (consec == CONSEC_W'(ERR_LIMIT - 1)) begin
              state      <= SYNC;
              bus.locked <= 1'b0;
              consec     <= '0;
            end else begin
              consec <= consec + 1'b1;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_counter_monitor;
  typedef struct packed {
    logic       mode;
    logic       locked;
    logic       err;
    logic [1:0] code;
    logic [7:0] ecnt;
  } resp_t;

  logic clk;
  logic rst;
  counter_monitor_if bus();

  counter_monitor dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  resp_t exp_q[$];
  string name_q[$];
  int    tests  = 0;
  int    failed = 0;
  logic [7:0] exp_ecnt = 8'd0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      resp_t exp_r, act;
      string nm;
      exp_r = exp_q.pop_front();
      nm    = name_q.pop_front();
      act   = {bus.mode_out, bus.locked, bus.err, 2'(bus.err_code), bus.err_cnt};
      tests++;
      if (act !== exp_r) begin
        failed++;
        $display("FAIL %s: got mode=%0b locked=%0b err=%0b code=%0d err_cnt=%0d, expected mode=%0b locked=%0b err=%0b code=%0d err_cnt=%0d",
                 nm, act.mode, act.locked, act.err, act.code, act.ecnt,
                 exp_r.mode, exp_r.locked, exp_r.err, exp_r.code, exp_r.ecnt);
      end
    end
  end

  task automatic step(input logic r, input logic v, input int val,
                      input logic m, input logic l, input logic e,
                      input logic [1:0] c, input string nm);
    rst         = r;
    bus.cnt_vld = v;
    bus.cnt     = 10'(val);
    if (!r)
      exp_ecnt = 8'd0;
    else if (e && exp_ecnt != 8'hFF)
      exp_ecnt = exp_ecnt + 8'd1;
    exp_q.push_back('{m, l, e, c, exp_ecnt});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'd0, "reset");
  endtask

  initial begin
    rst         = 1'b1;
    bus.cnt_vld = 1'b0;
    bus.cnt     = '0;
    @(negedge clk);
    #1;

    // basic up stream
    do_reset();
    step(1, 1, 17,  0, 1, 0, 0, "seed_17");
    step(1, 1, 21,  1, 1, 0, 0, "up_21");
    step(1, 1, 25,  1, 1, 0, 0, "up_25");

    // skip value, up direction
    do_reset();
    step(1, 1, -55, 0, 1, 0, 0, "seed_m55");
    step(1, 1, -51, 1, 1, 0, 0, "up_m51");
    step(1, 1, -43, 1, 1, 0, 0, "skip_up_m43");
    step(1, 1, -47, 1, 1, 1, 2, "skip_val_err");
    step(1, 1, -39, 1, 1, 0, 0, "up_m39");

    // skip value, down direction
    do_reset();
    step(1, 1, -27, 0, 1, 0, 0, "seed_m27");
    step(1, 1, -37, 0, 1, 0, 0, "dn_m37");
    step(1, 1, -57, 0, 1, 0, 0, "skip_dn_m57");

    // wrap both ways and top boundary
    do_reset();
    step(1, 1, 268,  0, 1, 0, 0, "seed_268");
    step(1, 1, -261, 1, 1, 0, 0, "wrap_up");
    do_reset();
    step(1, 1, -262, 0, 1, 0, 0, "seed_m262");
    step(1, 1, -258, 1, 1, 0, 0, "up_m258");
    step(1, 1, 265,  0, 1, 0, 0, "wrap_dn");
    step(1, 1, 269,  1, 1, 0, 0, "up_max");
    step(1, 1, -260, 1, 1, 0, 0, "wrap_up_from_max");

    // range boundaries in SYNC
    do_reset();
    step(1, 1, -264, 0, 0, 1, 1, "below_min");
    step(1, 1, 270,  0, 0, 1, 1, "above_max");
    step(1, 1, -263, 0, 1, 0, 0, "seed_min");
    step(1, 1, -259, 1, 1, 0, 0, "up_from_min");

    // step/range errors, code hold over gaps, lock loss and relock
    do_reset();
    step(1, 1, 17,  0, 1, 0, 0, "seed_17b");
    step(1, 1, 17,  0, 1, 1, 3, "hold_err");
    step(1, 1, 300, 0, 1, 1, 1, "range_err");
    step(1, 0, 17,  0, 1, 0, 1, "gap_code_held0");
    step(1, 0, 17,  0, 1, 0, 1, "gap_code_held1");
    step(1, 1, 21,  1, 1, 0, 0, "recover_21");
    step(1, 1, 21,  1, 1, 1, 3, "bad1");
    step(1, 1, 21,  1, 1, 1, 3, "bad2");
    step(1, 1, 21,  1, 0, 1, 3, "bad3_unlock");
    step(1, 1, 100, 1, 1, 0, 0, "relock_100");
    step(1, 1, 104, 1, 1, 0, 0, "up_104");
    for (int i = 0; i < 5; i++)
      step(1, 0, 17, 1, 1, 0, 0, "vld_gap");
    step(1, 1, 108, 1, 1, 0, 0, "after_gap_108");

    // reset wins over a concurrent bad sample and discards tracking
    step(0, 1, 17, 0, 0, 0, 0, "rst_with_bad");
    step(1, 1, 5,  0, 1, 0, 0, "seed_after_rst");
    step(1, 1, -5, 0, 1, 0, 0, "dn_m5");

    // error counter saturation
    do_reset();
    for (int i = 0; i < 260; i++)
      step(1, 1, 300, 0, 0, 1, 1, "sat_err");
    step(1, 1, 0, 0, 1, 0, 0, "sat_hold_seed");

    bus.cnt_vld = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    #6;
    if (exp_q.size() > 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/counter_monitor.md
# counter_monitor

Passive decoder for the up/down counter's `cnt` stream: it recovers the count direction (`mode`) from consecutive samples and flags illegal values or steps.
- Sits beside the counter on the same clock.
- Receives `cnt` plus a qualifier and tracks the expected next value.
- Reports decoded mode, lock status, error pulses and a saturating error count.

## Interface
- `CNT_W`, 10, counter width (signed)
- `CNT_MIN`, -263, lowest legal value
- `CNT_MAX`, 269, highest legal value
- `RST_VAL`, 17, counter value after reset
- `SKIP_VAL`, -47, value the counter never produces
- `UP_STEP`, 4, increment when mode=1
- `DN_STEP`, 10, decrement when mode=0
- `ERR_LIMIT`, 3, consecutive errors that drop lock
- `ERRCNT_W`, 8, error counter width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-low
- `cnt_vld`  in  1  `cnt` sample valid this cycle
- `cnt`  in  CNT_W signed  observed counter value
- `mode_out`  out  1  decoded direction of last legal step (1 = up)
- `locked`  out  1  monitor tracking a consistent stream
- `err`  out  1  one-cycle error pulse
- `err_code`  out  2  0 none, 1 range, 2 skip value, 3 bad step; held until next accepted sample
- `err_cnt`  out  ERRCNT_W  total errors since reset, saturating

## Operation
- Legal successor of v, up direction (N = CNT_MAX-CNT_MIN+1 = 533):
  - v+UP_STEP, except v = SKIP_VAL-UP_STEP (-51), which goes to v+2*UP_STEP (-43).
  - If the result exceeds CNT_MAX, subtract N.
- Legal successor of v, down direction:
  - v-DN_STEP, except v = SKIP_VAL+DN_STEP (-37), which goes to v-2*DN_STEP (-57).
  - If the result is below CNT_MIN, add N.
- Arithmetic is done at CNT_W+2 signed bits, then truncated.
- FSM has two states:
  - SYNC (reset state): first legal sample (in range, ≠ SKIP_VAL) becomes reference `ref` → TRACK. An illegal sample raises err and stays in SYNC.
  - TRACK: each valid sample is checked against up_next(ref) and dn_next(ref).
- TRACK check results:
  - Equals up_next(ref): mode_out=1, consec=0.
  - Equals dn_next(ref): mode_out=0, consec=0.
  - No match: err, code 3 (or 1/2 if the value itself is illegal), consec+1.
- Reference update in TRACK: `ref` takes every legal-valued sample, including bad-step ones. This resynchronises the monitor.
- Lock loss: consec reaching ERR_LIMIT → SYNC, locked=0, consec=0.
- Error priority: range > skip > step.
- Sample equal to `ref` (hold) is a bad step.
- `cnt_vld`=0: no check, no state change, err=0.
- `err_cnt` increments on every err and saturates at all-ones.
- The first sample after reset needn't equal RST_VAL; it only seeds `ref`.

## Timing
- Reset, sampled on a rising edge with `rst`=0. Registered values:
  - state=SYNC, ref=RST_VAL, consec=0
  - mode_out=0, locked=0, err=0, err_code=0, err_cnt=0
- Reset overrides `cnt_vld` in the same cycle. Reset mid-stream discards all tracking.
- All outputs are registered. A sample on edge k appears on outputs after edge k, so latency is 1 cycle.
- `locked` rises on the edge that accepts the seeding sample. It falls on the edge of the ERR_LIMIT-th consecutive error.
- `err` is high for exactly one cycle per faulty sample. Back-to-back faulty samples give back-to-back pulses.
- Wrap and skip corrections are combinational from `ref`. There are no bubbles; one sample is accepted per cycle.

## Structure
- Package `counter_pkg`:
  - CNT_W, CNT_MIN, CNT_MAX, RST_VAL, SKIP_VAL, UP_STEP, DN_STEP
  - state enum {SYNC, TRACK}
  - err_code enum {E_NONE, E_RANGE, E_SKIP, E_STEP}
- Sub-module `counter_next`: combinational, takes ref and returns up_next, dn_next and legal(v). It is reusable by a future counter RTL rewrite.

## Test plan
- Reset, then 17, 21, 25 with vld every cycle:
  - locked=1 after the first edge.
  - mode_out=1 on the 21 and 25 samples.
  - err=0 throughout, err_cnt=0.
- Skip, up: ref -55, then -51, -43 → both accepted, mode_out=1, no err. Inject -47 → err=1, err_code=2.
- Skip, down: ref -27, then -37, -57 → mode_out=0, no err.
- Wrap, up: 268 → -261 (up) accepted. Wrap, down: -258 → 265 (down) accepted.
- Errors:
  - 17, 17 → err code 3.
  - 300 → code 1.
  - Three consecutive bad steps → locked=0, SYNC.
  - Next legal sample relocks.
  - err_cnt equals the error count and saturates at 255 after 260 injected errors.
- vld gaps and reset:
  - Deassert `cnt_vld` for 5 cycles mid-stream → no err, ref unchanged.
  - `rst`=0 concurrent with a valid bad sample → all outputs reset, no err pulse.
